branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Parametrised, registered successor to the combinational branch unit. Owns the program counter and a return-address stack (RAS), and resolves one control-flow op per accepted cycle. Supports signed and unsigned compares, `jal` push and `jr` pop, a stall input, and registered status outputs. Sits between decode/register-read and instruction fetch; `pc_out` drives fetch directly.

## Interface
- `XLEN`, 32: datapath, PC and immediate width.
- `RAS_DEPTH`, 4: RAS entries, ≥2.
- `PC_STEP`, 4: sequential PC increment.
- `RESET_PC`, 0: PC value at reset.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: op present this cycle.
- `stall` in 1: hold all state; overrides `in_valid`.
- `ctrl` in 4: opcode (see Operation).
- `uns` in 1: 1 = unsigned compare, 0 = signed.
- `op1`, `op2` in XLEN: compare operands; `op1` is also the `jr` fallback target.
- `imm` in XLEN: branch/jump offset, two's complement.
- `pc_out` out XLEN: current PC register.
- `ra_out` out XLEN: RAS top entry; 0 when the RAS is empty.
- `ras_count` out clog2(RAS_DEPTH+1): number of valid RAS entries.
- `out_valid` out 1: one-cycle pulse, an op retired on the last edge.
- `taken` out 1: one-cycle pulse, the retired op redirected the PC.
- `ras_overflow` out 1: one-cycle pulse, a push overwrote the oldest entry.
- `ras_underflow` out 1: one-cycle pulse, a `jr` was executed on an empty RAS.
- `illegal` out 1: one-cycle pulse, the retired `ctrl` was 10–15.

## Operation
- Accept condition: `in_valid & ~stall` at a rising edge. The current PC is `pc_out`; it is not an input.
- Definitions: `seq = pc_out + PC_STEP`, `tgt = pc_out + imm`. Both are modulo 2^XLEN; carry is dropped.
- Compares use signed or unsigned interpretation of `op1`/`op2` according to `uns`.
- `ctrl` encoding and action:
  - 0 beq: branch if `op1 == op2`.
  - 1 bne: branch if `op1 != op2`.
  - 2 bgt: branch if `op1 > op2`.
  - 3 bge: branch if `op1 >= op2`.
  - 4 blt: branch if `op1 < op2`.
  - 5 ble: branch if `op1 <= op2`.
  - For ops 0–5: if the condition holds, `pc <= tgt` and `taken = 1`; otherwise `pc <= seq`.
  - 6 j: `pc <= tgt`, `taken = 1`.
  - 7 jal: `pc <= tgt`, `taken = 1`, push `seq` onto the RAS.
  - 8 jr: pop the RAS and set `pc <=` the popped value, `taken = 1`. If the RAS is empty, `pc <= op1`, `taken = 1`, and `ras_underflow` pulses.
  - 9 nop: `pc <= seq`.
  - 10–15: `pc <= seq` and `illegal` pulses; the RAS is unchanged.
- RAS structure: circular buffer, `RAS_DEPTH` entries. The top pointer wraps modulo `RAS_DEPTH`.
  - Push when `ras_count < RAS_DEPTH`: `ras_count` increments.
  - Push when full: the oldest entry is overwritten, `ras_count` stays `RAS_DEPTH`, and `ras_overflow` pulses.
  - Pop: returns the top entry, `ras_count` decrements, and the previous entry becomes the top.
- Only one op is accepted per cycle, so push and pop never coincide.
- Stall or `~in_valid`: PC, RAS and `ras_count` hold. All pulse outputs are 0 on the next cycle.

## Timing
- Reset state (asynchronous, immediate on `rst`):
  - `pc_out = RESET_PC`, `ra_out = 0`, `ras_count = 0`.
  - All pulse outputs are 0 and all RAS entries are cleared.
- Reset asserted mid-operation discards any in-flight op; there is no pending state after release.
- Latency is 1 cycle. An op accepted at edge N updates `pc_out`, `ra_out` and `ras_count`, and raises the pulses, after edge N. The pulses are valid for exactly one cycle.
- Throughput is 1 op per cycle. Back-to-back ops use the `pc_out` already updated by the previous op.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `stall` is sampled at the edge. The first edge after `stall` deasserts accepts the op presented at that edge.

## Test plan
- Reset, then `beq` with 45/36 and imm 20: `pc_out = 4`, `taken = 0`. Next, `beq` with 45/45 and imm 20: `pc_out = 24`, `taken = 1`, `out_valid` high for 1 cycle each.
- Sign mode: `bgt` with `op1 = 0xFFFFFFFF` and `op2 = 1`.
  - `uns = 0`: not taken, `pc_out += 4`.
  - `uns = 1`: taken, `pc_out += imm`.
- Call/return: with `pc_out = 8`, `jal` imm 100 gives `pc_out = 108`, `ra_out = 12`, `ras_count = 1`. A following `jr` gives `pc_out = 12`, `ras_count = 0`, `ra_out = 0`.
- RAS limits with `RAS_DEPTH = 4`: five consecutive `jal`.
  - On the fifth: `ras_overflow` pulses and `ras_count = 4`.
  - Then five `jr` with `op1 = 0x500`: the first four return the last four pushed addresses in LIFO order. The fifth gives `pc_out = 0x500` and `ras_underflow` pulses.
- Stall: `in_valid = 1`, `stall = 1` for 3 cycles. PC and RAS are unchanged and `out_valid = 0`. The op executes on the first unstalled edge.
- Reset and illegal opcode:
  - Assert `rst` between edges after two `jal`: `pc_out = 0` and `ras_count = 0` immediately, before the next edge.
  - `ctrl = 12`: `illegal` pulses and `pc_out += 4`.

Source files
------------

// File: rtl/branch_pc_unit_if.sv
// Bus bundle between decode/register-read (master) and the branch/PC unit (slave).
// The interface parameters must match the ones given to branch_pc_unit.
interface branch_pc_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic            in_valid;
  logic            stall;
  logic [3:0]      ctrl;
  logic            uns;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] ra_out;
  logic [CW-1:0]   ras_count;
  logic            out_valid;
  logic            taken;
  logic            ras_overflow;
  logic            ras_underflow;
  logic            illegal;

  modport master (
    output in_valid, stall, ctrl, uns, op1, op2, imm,
    input  pc_out, ra_out, ras_count, out_valid, taken,
           ras_overflow, ras_underflow, illegal
  );

  modport slave (
    input  in_valid, stall, ctrl, uns, op1, op2, imm,
    output pc_out, ra_out, ras_count, out_valid, taken,
           ras_overflow, ras_underflow, illegal
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Registered branch resolver: owns the PC and a circular return-address stack,
// retires one control-flow op per accepted cycle with one-cycle status pulses.
module branch_pc_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  branch_pc_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  typedef enum logic [3:0] {
    OP_BEQ = 4'd0, OP_BNE = 4'd1, OP_BGT = 4'd2, OP_BGE = 4'd3, OP_BLT = 4'd4,
    OP_BLE = 4'd5, OP_J   = 4'd6, OP_JAL = 4'd7, OP_JR  = 4'd8, OP_NOP = 4'd9
  } op_e;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, ra_q, ra_d;
  logic            ov_q, ov_d, tk_q, tk_d, of_q, of_d, uf_q, uf_d, il_q, il_d;
  logic            push;
  logic [XLEN-1:0] seq, tgt;
  logic            eq, lt, accept, cond;

  // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);

  // Next-state: decode the op, resolve the branch and update the RAS.
  always_comb begin
    pc_d   = pc_q;
    ra_d   = ra_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ov_d   = 1'b0;
    tk_d   = 1'b0;
    of_d   = 1'b0;
    uf_d   = 1'b0;
    il_d   = 1'b0;
    push   = 1'b0;
    cond   = 1'b0;
    seq    = pc_q + XLEN'(PC_STEP);
    tgt    = pc_q + bus.imm;
    eq     = (bus.op1 == bus.op2);
    lt     = bus.uns ? (bus.op1 < bus.op2) : ($signed(bus.op1) < $signed(bus.op2));
    accept = bus.in_valid & ~bus.stall;

    if (accept) begin
      ov_d = 1'b1;
      case (bus.ctrl)
        OP_BEQ: cond = eq;
        OP_BNE: cond = ~eq;
        OP_BGT: cond = ~lt & ~eq;
        OP_BGE: cond = ~lt;
        OP_BLT: cond = lt;
        OP_BLE: cond = lt | eq;
        OP_J:   cond = 1'b1;
        OP_JAL: begin
          cond  = 1'b1;
          push  = 1'b1;
          ptr_d = ptr_inc;
          ra_d  = seq;
          if (cnt_q == CW'(RAS_DEPTH)) of_d = 1'b1;
          else                         cnt_d = cnt_q + CW'(1);
        end
        OP_JR: begin
          tk_d = 1'b1;
          if (cnt_q == '0) begin
            pc_d = bus.op1;
            uf_d = 1'b1;
          end else begin
            pc_d  = ras_mem[ptr_q];
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CW'(1);
            ra_d  = (cnt_q == CW'(1)) ? '0 : ras_mem[ptr_dec];
          end
        end
        OP_NOP:  cond = 1'b0;
        default: il_d = 1'b1;
      endcase
      if (bus.ctrl != OP_JR) begin
        pc_d = cond ? tgt : seq;
        tk_d = cond;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ra_q  <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      tk_q  <= 1'b0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
      il_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ra_q  <= ra_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      tk_q  <= tk_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
      il_q  <= il_d;
      if (push) ras_mem[ptr_d] <= seq;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.ra_out        = ra_q;
  assign bus.ras_count     = cnt_q;
  assign bus.out_valid     = ov_q;
  assign bus.taken         = tk_q;
  assign bus.ras_overflow  = of_q;
  assign bus.ras_underflow = uf_q;
  assign bus.illegal       = il_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed plus randomized bench for branch_pc_unit against a queue-based
// reference model of the PC and return-address stack.
module tb_branch_pc_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  branch_pc_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH), .PC_STEP(4), .RESET_PC('0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit e_ov, e_tk, e_of, e_uf, e_il;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_pc = 32'd0;
    m_ras.delete();
    {e_ov, e_tk, e_of, e_uf, e_il} = '0;
  endfunction

  function automatic void model_step(bit acc, logic [3:0] c, bit u,
                                     logic [31:0] a, logic [31:0] b, logic [31:0] im);
    longint x, y;
    bit go;
    logic [31:0] seq, tgt;
    {e_ov, e_tk, e_of, e_uf, e_il} = '0;
    if (!acc) return;
    e_ov = 1;
    seq = m_pc + 32'd4;
    tgt = m_pc + im;
    x = u ? longint'(a) : longint'($signed(a));
    y = u ? longint'(b) : longint'($signed(b));
    go = 0;
    case (c)
      4'd0: go = (x == y);
      4'd1: go = (x != y);
      4'd2: go = (x > y);
      4'd3: go = (x >= y);
      4'd4: go = (x < y);
      4'd5: go = (x <= y);
      4'd6: go = 1;
      4'd7: begin
        go = 1;
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) begin
          m_ras.delete(0);
          e_of = 1;
        end
      end
      default: go = 0;
    endcase
    if (c == 4'd8) begin
      e_tk = 1;
      if (m_ras.size() == 0) begin
        m_pc = a;
        e_uf = 1;
      end else begin
        m_pc = m_ras.pop_back();
      end
    end else begin
      e_tk = go;
      m_pc = go ? tgt : seq;
    end
    e_il = (c >= 4'd10);
  endfunction

  task automatic check_all();
    logic [31:0] exp_ra;
    exp_ra = (m_ras.size() > 0) ? m_ras[$] : 32'd0;
    chk("pc_out", bus.pc_out, m_pc);
    chk("ra_out", bus.ra_out, exp_ra);
    chk("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
    chk("taken", 32'(bus.taken), 32'(e_tk));
    chk("ras_overflow", 32'(bus.ras_overflow), 32'(e_of));
    chk("ras_underflow", 32'(bus.ras_underflow), 32'(e_uf));
    chk("illegal", 32'(bus.illegal), 32'(e_il));
  endtask

  task automatic step(input bit v, input bit s, input logic [3:0] c, input bit u,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    bus.in_valid = v;
    bus.stall    = s;
    bus.ctrl     = c;
    bus.uns      = u;
    bus.op1      = a;
    bus.op2      = b;
    bus.imm      = im;
    @(posedge clk);
    model_step(v && !s, c, u, a, b, im);
    #1;
    check_all();
  endtask

  task automatic op(input logic [3:0] c, input bit u, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] im);
    step(1'b1, 1'b0, c, u, a, b, im);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", bus.pc_out, 32'd0);
    chk("rst_count", 32'(bus.ras_count), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.ctrl     = 4'd0;
    bus.uns      = 1'b0;
    bus.op1      = '0;
    bus.op2      = '0;
    bus.imm      = '0;
    model_reset();
    do_reset();

    // beq not taken, then taken
    op(4'd0, 0, 32'd45, 32'd36, 32'd20);
    chk("beq_nt_pc", bus.pc_out, 32'd4);
    chk("beq_nt_taken", 32'(bus.taken), 32'd0);
    op(4'd0, 0, 32'd45, 32'd45, 32'd20);
    chk("beq_t_pc", bus.pc_out, 32'd24);
    chk("beq_t_taken", 32'(bus.taken), 32'd1);
    step(0, 0, 4'd0, 0, 32'd1, 32'd1, 32'd8);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Signed vs unsigned bgt
    op(4'd2, 0, 32'hFFFF_FFFF, 32'd1, 32'd40);
    chk("bgt_signed_pc", bus.pc_out, 32'd28);
    op(4'd2, 1, 32'hFFFF_FFFF, 32'd1, 32'd40);
    chk("bgt_unsigned_pc", bus.pc_out, 32'd68);

    // Call/return from pc 8
    do_reset();
    op(4'd9, 0, 0, 0, 0);
    op(4'd9, 0, 0, 0, 0);
    op(4'd7, 0, 0, 0, 32'd100);
    chk("jal_pc", bus.pc_out, 32'd108);
    chk("jal_ra", bus.ra_out, 32'd12);
    op(4'd8, 0, 32'h500, 0, 0);
    chk("jr_pc", bus.pc_out, 32'd12);
    chk("jr_ra", bus.ra_out, 32'd0);

    // Overflow and underflow
    for (int i = 0; i < 5; i++) op(4'd7, 0, 0, 0, 32'd16);
    chk("ovf_pulse", 32'(bus.ras_overflow), 32'd1);
    chk("ovf_count", 32'(bus.ras_count), 32'd4);
    for (int i = 0; i < 5; i++) op(4'd8, 0, 32'h500, 0, 0);
    chk("unf_pc", bus.pc_out, 32'h500);
    chk("unf_pulse", 32'(bus.ras_underflow), 32'd1);

    // Stall holds for three cycles, then executes
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'd7, 0, 0, 0, 32'd64);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd0);
    end
    step(1, 0, 4'd7, 0, 0, 0, 32'd64);
    chk("unstall_taken", 32'(bus.taken), 32'd1);

    // Mid-operation reset, then illegal opcode
    op(4'd7, 0, 0, 0, 32'd8);
    op(4'd7, 0, 0, 0, 32'd8);
    do_reset();
    op(4'd12, 0, 0, 0, 32'd8);
    chk("illegal_pulse", 32'(bus.illegal), 32'd1);
    chk("illegal_pc", bus.pc_out, 32'd4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 1) == 1) begin
        a = 32'($urandom_range(0, 6)) - 32'd3;
        b = 32'($urandom_range(0, 6)) - 32'd3;
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
           ($urandom_range(0, 2) == 0) ? 4'(7 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), a, b, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
